// File: rtl/mem_ctrl_if.sv
// Request/response bundle between mem_ctrl, its IF/LSB clients and the byte-wide RAM port.
// Latency: none, wires only.
// Backpressure: requests are level-held until the matching Success pulse; io_buffer_full stalls IO stores.
// Ports (slave = controller view): in rdy, Clear, IF_S/IF_Addr, LSB_S/LSB_Wr/LSB_Size/LSB_Addr/LSB_Data,
//   mem_din, io_buffer_full; out IF_Success/IF_Inst, LSB_Success/LSB_Result, mem_dout, mem_a, mem_wr.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rdy;
  logic              Clear;
  logic              IF_S;
  logic [ADDR_W-1:0] IF_Addr;
  logic              IF_Success;
  logic [DATA_W-1:0] IF_Inst;
  logic              LSB_S;
  logic              LSB_Wr;
  logic [1:0]        LSB_Size;
  logic [ADDR_W-1:0] LSB_Addr;
  logic [DATA_W-1:0] LSB_Data;
  logic              LSB_Success;
  logic [DATA_W-1:0] LSB_Result;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport slave (
    input  rdy, Clear, IF_S, IF_Addr, LSB_S, LSB_Wr, LSB_Size, LSB_Addr, LSB_Data,
           mem_din, io_buffer_full,
    output IF_Success, IF_Inst, LSB_Success, LSB_Result, mem_dout, mem_a, mem_wr
  );

  modport master (
    output rdy, Clear, IF_S, IF_Addr, LSB_S, LSB_Wr, LSB_Size, LSB_Addr, LSB_Data,
           mem_din, io_buffer_full,
    input  IF_Success, IF_Inst, LSB_Success, LSB_Result, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide RAM port between IF and LSB; assembles little-endian words one byte per cycle.
// Latency: read N+1 edges after grant (N = 1/2/4 bytes, IF always 4), write N edges after grant.
// Backpressure: rdy=0 freezes everything; IO-region stores wait while io_buffer_full; Clear aborts reads.
// Ports: clk, rst (async active-high), bus (mem_ctrl_if.slave, all request/response/RAM signals).
// Build option: define MEMCTRL_RR_ARB_EN for round-robin arbitration (default: fixed LSB priority).
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  state_t            state_q, state_n;
  logic [2:0]        cnt_q, cnt_n;      // edges since grant; selects address, byte lane and finish
  logic [2:0]        len_q, len_n;      // transfer length in bytes
  logic [ADDR_W-1:0] base_q, base_n;
  logic [DATA_W-1:0] wdat_q, wdat_n;
  logic [DATA_W-1:0] rbuf_q, rbuf_n;
  logic [ADDR_W-1:0] mem_a_q, mem_a_n;
  logic [7:0]        mem_dout_q, mem_dout_n;
  logic              mem_wr_q, mem_wr_n;
  logic              if_success_q, if_success_n;
  logic              lsb_success_q, lsb_success_n;
  logic [DATA_W-1:0] if_inst_q, if_inst_n;
  logic [DATA_W-1:0] lsb_result_q, lsb_result_n;

  logic [ADDR_W-1:0] cur_a;
  logic [1:0]        rd_idx;
  logic [2:0]        lsb_len;
  logic              io_stall, lsb_req, if_req, lsb_first, grant_lsb, grant_go;

  assign cur_a   = base_q + {{(ADDR_W-3){1'b0}}, cnt_q};
  // RAM returns data two edges after the address, so edge k fills byte k-2.
  assign rd_idx  = 2'(cnt_q - 3'd2);
  assign lsb_len = (bus.LSB_Size == 2'd0) ? 3'd1 : (bus.LSB_Size == 2'd1) ? 3'd2 : 3'd4;

  assign io_stall = bus.LSB_Wr && (bus.LSB_Addr[17:16] == 2'b11) && bus.io_buffer_full;
  assign lsb_req  = bus.LSB_S && !io_stall;
  assign if_req   = bus.IF_S;

`ifdef MEMCTRL_RR_ARB_EN
  logic last_lsb_q;  // 1: LSB won the previous grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_lsb_q <= 1'b0;
    else if (bus.rdy && grant_go) last_lsb_q <= grant_lsb;
  end
  assign lsb_first = !last_lsb_q;
`else
  assign lsb_first = 1'b1;
`endif

  assign grant_lsb = lsb_req && (lsb_first || !if_req);
  // No grant on the cycle a Success is showing: the requester has not yet dropped S.
  assign grant_go  = (state_q == IDLE) && !bus.Clear && !if_success_q && !lsb_success_q &&
                     (lsb_req || if_req);

  always_comb begin
    state_n       = state_q;
    cnt_n         = cnt_q;
    len_n         = len_q;
    base_n        = base_q;
    wdat_n        = wdat_q;
    rbuf_n        = rbuf_q;
    mem_a_n       = mem_a_q;
    mem_dout_n    = mem_dout_q;
    mem_wr_n      = mem_wr_q;
    if_success_n  = 1'b0;
    lsb_success_n = 1'b0;
    if_inst_n     = if_inst_q;
    lsb_result_n  = lsb_result_q;

    case (state_q)
      IDLE: begin
        if (grant_go) begin
          cnt_n  = 3'd1;
          rbuf_n = '0;
          if (grant_lsb) begin
            base_n  = bus.LSB_Addr;
            mem_a_n = bus.LSB_Addr;
            len_n   = lsb_len;
            wdat_n  = bus.LSB_Data;
            if (bus.LSB_Wr) begin
              state_n    = LS_WR;
              mem_wr_n   = 1'b1;
              mem_dout_n = bus.LSB_Data[7:0];
            end else begin
              state_n = LS_RD;
            end
          end else begin
            base_n  = bus.IF_Addr;
            mem_a_n = bus.IF_Addr;
            len_n   = 3'd4;
            state_n = IF_RD;
          end
        end
      end

      IF_RD, LS_RD: begin
        if (bus.Clear) begin
          state_n  = IDLE;
          cnt_n    = '0;
          mem_wr_n = 1'b0;
          mem_a_n  = '0;
        end else begin
          mem_a_n = (cnt_q < len_q) ? cur_a : '0;
          if (cnt_q >= 3'd2) rbuf_n[{rd_idx, 3'b000} +: 8] = bus.mem_din;
          if (cnt_q == len_q + 3'd1) begin
            state_n = IDLE;
            cnt_n   = '0;
            if (state_q == IF_RD) begin
              if_success_n = 1'b1;
              if_inst_n    = rbuf_n;
            end else begin
              lsb_success_n = 1'b1;
              lsb_result_n  = rbuf_n;
            end
          end else begin
            cnt_n = cnt_q + 3'd1;
          end
        end
      end

      LS_WR: begin
        // Stores are committed once granted, so Clear is ignored here.
        if (cnt_q < len_q) begin
          mem_a_n    = cur_a;
          mem_dout_n = wdat_q[{cnt_q[1:0], 3'b000} +: 8];
          cnt_n      = cnt_q + 3'd1;
        end else begin
          state_n       = IDLE;
          cnt_n         = '0;
          mem_wr_n      = 1'b0;
          mem_a_n       = '0;
          mem_dout_n    = '0;
          lsb_success_n = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      len_q         <= '0;
      base_q        <= '0;
      wdat_q        <= '0;
      rbuf_q        <= '0;
      mem_a_q       <= '0;
      mem_dout_q    <= '0;
      mem_wr_q      <= 1'b0;
      if_success_q  <= 1'b0;
      lsb_success_q <= 1'b0;
      if_inst_q     <= '0;
      lsb_result_q  <= '0;
    end else if (bus.rdy) begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      len_q         <= len_n;
      base_q        <= base_n;
      wdat_q        <= wdat_n;
      rbuf_q        <= rbuf_n;
      mem_a_q       <= mem_a_n;
      mem_dout_q    <= mem_dout_n;
      mem_wr_q      <= mem_wr_n;
      if_success_q  <= if_success_n;
      lsb_success_q <= lsb_success_n;
      if_inst_q     <= if_inst_n;
      lsb_result_q  <= lsb_result_n;
    end
  end

  assign bus.mem_a       = mem_a_q;
  assign bus.mem_dout    = mem_dout_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.IF_Success  = if_success_q;
  assign bus.IF_Inst     = if_inst_q;
  assign bus.LSB_Success = lsb_success_q;
  assign bus.LSB_Result  = lsb_result_q;

endmodule
